// File: rtl/axi_sram_responder.sv
// AXI responder serving one write and one read burst concurrently from an on-chip SRAM of 64-byte lines.
// Optional out-of-range beat detection: define AXI_SRAM_RANGE_CHECK_EN.
module axi_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  awid,
  input  logic [63:0]  awaddr,
  input  logic [7:0]   awlen,
  input  logic [2:0]   awsize,
  input  logic         awvalid,
  output logic         awready,
  input  logic [511:0] wdata,
  input  logic [63:0]  wstrb,
  input  logic         wlast,
  input  logic         wuser,
  input  logic         wvalid,
  output logic         wready,
  output logic [15:0]  bid,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready,
  input  logic [15:0]  arid,
  input  logic [63:0]  araddr,
  input  logic [7:0]   arlen,
  input  logic [2:0]   arsize,
  input  logic         arvalid,
  output logic         arready,
  output logic [15:0]  rid,
  output logic [511:0] rdata,
  output logic [1:0]   rresp,
  output logic         rlast,
  output logic         ruser,
  output logic         rvalid,
  input  logic         rready
);

  localparam int unsigned LINES = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  logic [511:0] mem [LINES];

  // Holds the ready outputs low while reset is asserted without an input-to-ready path.
  logic live;

  w_state_t              w_state, w_next;
  logic [63:0]           w_addr, w_off;
  logic [7:0]            w_len, w_cnt;
  logic [15:0]           w_id;
  logic                  w_err, w_ok, aw_hs, w_hs, w_last_beat;
  logic [DEPTH_LOG2-1:0] w_line;

  r_state_t              r_state, r_next;
  logic [63:0]           r_addr, r_off;
  logic [7:0]            r_len;
  logic [8:0]            r_cnt;
  logic [15:0]           r_id;
  logic                  r_ok, ar_hs, r_issue, r_done;
  logic [DEPTH_LOG2-1:0] r_line;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_off       = w_addr - BASE_ADDR;
  assign w_line      = w_off[DEPTH_LOG2+5:6];
  assign w_last_beat = (w_cnt == w_len);

  assign ar_hs   = arvalid && arready;
  assign r_off   = r_addr - BASE_ADDR;
  assign r_line  = r_off[DEPTH_LOG2+5:6];
  assign r_issue = (r_state == R_BURST) && (r_cnt <= {1'b0, r_len}) && (!rvalid || rready);
  assign r_done  = rvalid && rready && rlast;

`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam logic [63:0] TOP_ADDR = BASE_ADDR + (64'd64 << DEPTH_LOG2);
  assign w_ok = (w_addr >= BASE_ADDR) && (w_addr < TOP_ADDR);
  assign r_ok = (r_addr >= BASE_ADDR) && (r_addr < TOP_ADDR);
`else
  assign w_ok = 1'b1;
  assign r_ok = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{awsize, arsize, wuser, w_off[63:DEPTH_LOG2+6], w_off[5:0],
                         r_off[63:DEPTH_LOG2+6], r_off[5:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = live && (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bid     = w_id;
    bresp   = {w_err, 1'b0};
  end

  // The beat count alone ends a burst; a misplaced wlast only marks the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (aw_hs) begin
      w_id   <= awid;
      w_addr <= awaddr;
      w_len  <= awlen;
      w_cnt  <= '0;
      w_err  <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + 64'd64;
      w_cnt  <= w_cnt + 8'd1;
      if ((wlast != w_last_beat) || !w_ok) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int unsigned b = 0; b < 64; b++) begin
        if (wstrb[b]) mem[w_line][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_BURST;
      R_BURST: if (r_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = live && (r_state == R_IDLE);
    ruser   = 1'b0;
  end

  // Reads sample mem before the same-edge write lands, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id   <= arid;
        r_addr <= araddr;
        r_len  <= arlen;
        r_cnt  <= '0;
      end
      if (r_issue) begin
        r_addr <= r_addr + 64'd64;
        r_cnt  <= r_cnt + 9'd1;
        rvalid <= 1'b1;
        rid    <= r_id;
        rlast  <= (r_cnt == {1'b0, r_len});
        rdata  <= r_ok ? mem[r_line] : '0;
        rresp  <= r_ok ? 2'b00 : 2'b10;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a line-array model predicts every B and R beat,
// checked each cycle by one compare process, plus literal pins on selected results.
module tb_axi_sram_responder;

  localparam int unsigned DL   = 10;
  localparam logic [63:0] BASE = 64'h0;

  logic         clk, rst_n;
  logic [15:0]  awid, arid, bid, rid;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic         awvalid, awready, wlast, wuser, wvalid, wready, bvalid, bready;
  logic [511:0] wdata, rdata;
  logic [63:0]  wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rlast, ruser, rvalid, rready;

  axi_sram_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {logic [15:0] id; logic [511:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct {logic [15:0] id; logic [1:0] resp;} bexp_t;

  int tests = 0, fails = 0;
  int cyc = 0, rdone = 0, bdone = 0, last_hs_edge = 0;
  logic [511:0] mm [1 << DL];
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t ce;
  bexp_t cb;
  logic [511:0] last_rdata;
  logic [1:0]   last_rresp, last_bresp;
  logic [15:0]  last_bid;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic in_range(input logic [63:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    return (a >= BASE) && (a < BASE + (64'd64 << DL));
`else
    return 1'b1;
`endif
  endfunction

  function automatic int line_of(input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) >> 6;
    return int'(o[DL-1:0]);
  endfunction

  function automatic logic [511:0] make_data(input logic [31:0] seed, input int b);
    logic [31:0] w;
    w = seed + 32'(b);
    return {16{w}};
  endfunction

  // Single compare process: every R beat and B response against the model queues.
  always @(negedge clk) begin
    if (rvalid) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 512'(rvalid), 512'(0));
      end else begin
        ce = rq[0];
        chk("rdata", rdata, ce.data);
        chk("rid", 512'(rid), 512'(ce.id));
        chk("rresp", 512'(rresp), 512'(ce.resp));
        chk("rlast", 512'(rlast), 512'(ce.last));
        chk("ruser", 512'(ruser), 512'(0));
        if (rready) begin
          void'(rq.pop_front());
          rdone++;
          last_rdata = rdata;
          last_rresp = rresp;
          if (rlast) last_hs_edge = cyc + 1;
        end
      end
    end
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        chk("bvalid_unexpected", 512'(bvalid), 512'(0));
      end else begin
        cb = bq.pop_front();
        chk("bid", 512'(bid), 512'(cb.id));
        chk("bresp", 512'(bresp), 512'(cb.resp));
        last_bid = bid;
        last_bresp = bresp;
        bdone++;
      end
    end
  end

  task automatic send_aw(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len);
    bit ok = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd6; awvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = awready;
      @(posedge clk); #1;
    end
    awvalid = 1'b0;
    if (!ok) chk("aw_timeout", 512'(ok), 512'(1));
  endtask

  task automatic write_burst(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [31:0] seed, input logic [63:0] strb,
                             input int wlast_at, input int delay);
    bit ok, err;
    int target, ln;
    logic [63:0] a;
    logic [511:0] d;
    err = 0;
    target = bdone + 1;
    bready = (delay == 0);
    send_aw(id, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 64'(64 * b);
      d = make_data(seed, b);
      wdata = d; wstrb = strb; wlast = (b == wlast_at); wuser = 1'b1; wvalid = 1'b1;
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
        @(negedge clk);
        if (b == 0 && n == 0) chk("wready_after_aw", 512'(wready), 512'(1));
        ok = wready;
        @(posedge clk); #1;
      end
      if (!ok) chk("w_timeout", 512'(ok), 512'(1));
      if (in_range(a)) begin
        ln = line_of(a);
        for (int i = 0; i < 64; i++) if (strb[i]) mm[ln][i*8 +: 8] = d[i*8 +: 8];
      end
      if (!in_range(a) || ((b == wlast_at) != (b == int'(len)))) err = 1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bq.push_back('{id, err ? 2'b10 : 2'b00});
    @(negedge clk); chk("bvalid_after_last_w", 512'(bvalid), 512'(1));
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      @(negedge clk); chk("bvalid_held", 512'(bvalid), 512'(1));
    end
    @(posedge clk); #1;
    bready = 1'b1;
    for (int n = 0; n < 50 && bdone < target; n++) begin
      @(posedge clk); #1;
    end
    chk("b_done", 512'(bdone >= target), 512'(1));
  endtask

  task automatic start_read(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            output int k);
    rexp_t e;
    logic [63:0] a;
    bit ok = 0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 64'(64 * b);
      e.id = id;
      e.last = (b == int'(len));
      if (in_range(a)) begin e.data = mm[line_of(a)]; e.resp = 2'b00; end
      else             begin e.data = '0;             e.resp = 2'b10; end
      rq.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arsize = 3'd6; arvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    k = cyc;
    if (!ok) chk("ar_timeout", 512'(ok), 512'(1));
  endtask

  task automatic read_burst(input logic [15:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int mode, input bit timing);
    int k, target;
    target = rdone + int'(len) + 1;
    rready = 1'b1;
    start_read(id, addr, len, k);
    for (int n = 0; n < 400 && rdone < target; n++) begin
      rready = (mode == 0) ? 1'b1 : (n % 2 == 0);
      @(negedge clk);
      if (timing && n == 0) chk("rvalid_at_k1", 512'(rvalid), 512'(0));
      if (timing && n == 1) chk("rvalid_at_k2", 512'(rvalid), 512'(1));
      @(posedge clk); #1;
    end
    chk("r_done", 512'(rdone >= target), 512'(1));
    if (timing) chk("rlast_edge", 512'(last_hs_edge), 512'(k + 2 + int'(len)));
    @(negedge clk); chk("arready_back", 512'(arready), 512'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd6; wdata = '0; wstrb = '0;
    wlast = 0; wuser = 0; arid = '0; araddr = '0; arlen = '0; arsize = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 512'(awready), 512'(0));
    chk("rst_wready", 512'(wready), 512'(0));
    chk("rst_bvalid", 512'(bvalid), 512'(0));
    chk("rst_bid_bresp", 512'({bid, bresp}), 512'(0));
    chk("rst_arready", 512'(arready), 512'(0));
    chk("rst_rvalid", 512'(rvalid), 512'(0));
    chk("rst_rid_rresp_rlast_ruser", 512'({rid, rresp, rlast, ruser}), 512'(0));
    chk("rst_rdata", rdata, 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_awready", 512'(awready), 512'(1));
    chk("idle_arready", 512'(arready), 512'(1));

    // single beat write then read
    write_burst(16'h12, 64'h40, 8'd0, 32'hDEADBEEF, '1, 0, 0);
    chk("pin_bid", 512'(last_bid), 512'(16'h12));
    chk("pin_bresp_ok", 512'(last_bresp), 512'(0));
    read_burst(16'h21, 64'h40, 8'd0, 0, 1);
    chk("pin_single_rdata", last_rdata, {16{32'hDEADBEEF}});

    // 16-beat burst, read back with rready toggling
    write_burst(16'h3, 64'h1000, 8'd15, 32'h1000_0000, '1, 15, 0);
    read_burst(16'h4, 64'h1000, 8'd15, 1, 0);
    chk("pin_beat15", last_rdata, {16{32'h1000_000F}});

    // partial strobe
    write_burst(16'h5, 64'h0, 8'd0, 32'hFFFF_FFFF, '1, 0, 0);
    write_burst(16'h6, 64'h0, 8'd0, 32'h0, 64'h1, 0, 0);
    read_burst(16'h7, 64'h0, 8'd0, 0, 0);
    chk("pin_strb_byte0", 512'(last_rdata[7:0]), 512'(8'h00));
    chk("pin_strb_byte1", 512'(last_rdata[15:8]), 512'(8'hFF));
    chk("pin_strb_byte63", 512'(last_rdata[511:504]), 512'(8'hFF));

    // early wlast: burst still runs 4 beats, SLVERR, late bready
    write_burst(16'h8, 64'h2000, 8'd3, 32'hA0, '1, 2, 5);
    chk("pin_wlast_slverr", 512'(last_bresp), 512'(2'b10));
    read_burst(16'h9, 64'h2000, 8'd3, 0, 1);
    chk("pin_wlast_beat3", last_rdata, {16{32'hA3}});

    // concurrent write and read on disjoint lines
    fork
      write_burst(16'hA, 64'h8000, 8'd7, 32'h8000, '1, 7, 0);
      read_burst(16'hB, 64'h1000, 8'd7, 0, 0);
    join

    // reset in the middle of a read
    rready = 1'b1;
    start_read(16'hC, 64'h8000, 8'd7, k);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 512'(rvalid), 512'(0));
    chk("midrst_arready", 512'(arready), 512'(0));
    chk("midrst_rdata", rdata, 512'(0));
    chk("midrst_rid_rlast", 512'({rid, rlast}), 512'(0));
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_arready", 512'(arready), 512'(1));
    chk("postrst_awready", 512'(awready), 512'(1));
    @(posedge clk); #1;
    read_burst(16'hD, 64'h8000, 8'd7, 0, 0);
    chk("pin_kept_after_reset", last_rdata, {16{32'h8007}});

    // last line plus one beat past the end
    write_burst(16'hE, 64'hFFC0, 8'd0, 32'h5A5A_5A5A, '1, 0, 0);
    read_burst(16'hF, 64'hFFC0, 8'd1, 0, 0);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    chk("pin_oob_rresp", 512'(last_rresp), 512'(2'b10));
    chk("pin_oob_rdata", last_rdata, 512'(0));
`else
    chk("pin_alias_rresp", 512'(last_rresp), 512'(2'b00));
    chk("pin_alias_rdata", last_rdata, {{63{8'hFF}}, 8'h00});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
